// File: rtl/conv3x3_engine_param.sv
// 3x3 convolution engine: run-time double-buffered coefficients, 4-stage valid/ready
// pipeline (multiply, pairwise add, final add, round/clamp) with global stall.
module conv3x3_engine_param #(
  parameter int DATA_W  = 8,
  parameter int COEF_W  = 8,
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 5,
  parameter int ACC_W   = DATA_W + COEF_W + 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [9*DATA_W-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [OUT_W-1:0]    out_data,
  output logic                out_sat,
  output logic                out_valid,
  input  logic                out_ready,
  input  logic                cfg_signed,
  input  logic [SHIFT_W-1:0]  cfg_shift,
  input  logic                cfg_relu,
  input  logic                coef_wr_en,
  input  logic [3:0]          coef_addr,
  input  logic [COEF_W-1:0]   coef_wdata,
  input  logic                coef_commit
);

  localparam int NTAP = 9;
  // Wide enough for any sum plus the largest rounding constant 2^(2^SHIFT_W-2).
  localparam int EXT_W = ACC_W + (1 << SHIFT_W) + 1;

  localparam logic signed [EXT_W-1:0] U_MAX = EXT_W'({OUT_W{1'b1}});
  localparam logic signed [EXT_W-1:0] S_MAX = EXT_W'({1'b0, {(OUT_W-1){1'b1}}});
  localparam logic signed [EXT_W-1:0] S_MIN = ~S_MAX;

  logic signed [COEF_W-1:0] shadow_q [NTAP];
  logic signed [COEF_W-1:0] active_q [NTAP];

  logic                     adv;
  logic                     s1_v, s2_v, s3_v, s4_v;
  logic signed [ACC_W-1:0]  s1_p [NTAP];
  logic signed [ACC_W-1:0]  s2_ps [5];
  logic signed [ACC_W-1:0]  s3_sum;
  logic [SHIFT_W-1:0]       s1_shift, s2_shift, s3_shift;
  logic                     s1_relu, s2_relu, s3_relu;
  logic [OUT_W-1:0]         s4_data;
  logic                     s4_sat;

  logic signed [ACC_W-1:0]  prod [NTAP];
  logic signed [EXT_W-1:0]  sum_x, rnd, r;
  logic [OUT_W-1:0]         clamp_data;
  logic                     clamp_sat;

  assign adv       = !s4_v || out_ready;
  assign in_ready  = adv;
  assign out_valid = s4_v;
  assign out_data  = s4_data;
  assign out_sat   = s4_sat;

  // Coefficient banks are writable regardless of pipeline stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the banks are explicitly reset because the engine must compute
      // with all-zero coefficients after reset; a reset-less RAM would hold X.
      for (int k = 0; k < NTAP; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignment makes a same-cycle commit copy the
      // pre-write shadow, while the write lands in the shadow only.
      if (coef_commit)
        active_q <= shadow_q;
      if (coef_wr_en && coef_addr < 4'(NTAP))
        shadow_q[coef_addr] <= coef_wdata;
    end
  end

  function automatic logic signed [ACC_W-1:0] mul_tap(
    input logic [DATA_W-1:0]        tap,
    input logic                     sgn,
    input logic signed [COEF_W-1:0] coef
  );
    logic signed [DATA_W:0]  tap_x;
    logic signed [ACC_W-1:0] tap_w;
    logic signed [ACC_W-1:0] coef_w;
    tap_x  = sgn ? {tap[DATA_W-1], tap} : {1'b0, tap};
    tap_w  = ACC_W'(tap_x);
    coef_w = ACC_W'(coef);
    return tap_w * coef_w;
  endfunction

  always_comb begin
    for (int k = 0; k < NTAP; k++)
      prod[k] = mul_tap(in_data[k*DATA_W +: DATA_W], cfg_signed, active_q[k]);
  end

  // Stage 4 combinational part: rounding right shift, then ReLU or signed clamp.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    sum_x      = EXT_W'(s3_sum);
    rnd        = '0;
    clamp_sat  = 1'b0;
    if (s3_shift != '0)
      rnd = EXT_W'(1) << (s3_shift - SHIFT_W'(1));
    r          = (sum_x + rnd) >>> s3_shift;
    clamp_data = r[OUT_W-1:0];
    if (s3_relu) begin
      if (r[EXT_W-1]) begin
        clamp_data = '0;
        clamp_sat  = 1'b1;
      end else if (r > U_MAX) begin
        clamp_data = U_MAX[OUT_W-1:0];
        clamp_sat  = 1'b1;
      end
    end else begin
      if (r < S_MIN) begin
        clamp_data = S_MIN[OUT_W-1:0];
        clamp_sat  = 1'b1;
      end else if (r > S_MAX) begin
        clamp_data = S_MAX[OUT_W-1:0];
        clamp_sat  = 1'b1;
      end
    end
  end

  // All stages move together; empty slots shift as bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v     <= 1'b0;
      s2_v     <= 1'b0;
      s3_v     <= 1'b0;
      s4_v     <= 1'b0;
      for (int k = 0; k < NTAP; k++)
        s1_p[k] <= '0;
      for (int j = 0; j < 5; j++)
        s2_ps[j] <= '0;
      s3_sum   <= '0;
      s1_shift <= '0;
      s2_shift <= '0;
      s3_shift <= '0;
      s1_relu  <= 1'b0;
      s2_relu  <= 1'b0;
      s3_relu  <= 1'b0;
      s4_data  <= '0;
      s4_sat   <= 1'b0;
    end else if (adv) begin
      s1_v     <= in_valid;
      s1_p     <= prod;
      s1_shift <= cfg_shift;
      s1_relu  <= cfg_relu;

      s2_v     <= s1_v;
      s2_ps[0] <= s1_p[0] + s1_p[1];
      s2_ps[1] <= s1_p[2] + s1_p[3];
      s2_ps[2] <= s1_p[4] + s1_p[5];
      s2_ps[3] <= s1_p[6] + s1_p[7];
      s2_ps[4] <= s1_p[8];
      s2_shift <= s1_shift;
      s2_relu  <= s1_relu;

      s3_v     <= s2_v;
      s3_sum   <= s2_ps[0] + s2_ps[1] + s2_ps[2] + s2_ps[3] + s2_ps[4];
      s3_shift <= s2_shift;
      s3_relu  <= s2_relu;

      s4_v     <= s3_v;
      s4_data  <= clamp_data;
      s4_sat   <= clamp_sat;
    end
  end

endmodule
